mux_nto1_rr: RTL and testbench
==============================

Name: mux_nto1_rr

Overview:
- Registered, parametrised N-to-1 multiplexer. Successor to the combinational 2-to-1 mux.
- Generalised in data width and channel count.
- Adds per-channel valid/ready handshaking, a one-stage output register, and two selection modes:
  - fixed: select by index.
  - round-robin: fair automatic selection among valid channels.
- Sits between several producer streams and a single consumer.

Parameters:
- DW, 4: data width per channel, >=1.
- NCH, 4: number of input channels, >=2.
- SW, $clog2(NCH): selector/grant width. Derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  NCH*DW  flattened channel data; channel c occupies bits [c*DW +: DW].
- in_valid  in  NCH  per-channel data valid.
- o_ready  out  NCH  per-channel accept. Combinational; transfer on channel c when in_valid[c] && o_ready[c].
- in_mode  in  1  0 = fixed select, 1 = round-robin.
- in_selector  in  SW  channel index used in fixed mode.
- o_result  out  DW  registered output data.
- o_valid  out  1  o_result holds an unconsumed word.
- o_grant  out  SW  index of the channel that supplied o_result.
- in_ready  in  1  consumer accept. Output transfer when o_valid && in_ready.

Behaviour:
- Reset, sampled on clk edge with rst_n=0:
  - o_valid=0, o_result=0, o_grant=0.
  - Round-robin pointer last=NCH-1, so the first search starts at channel 0.
  - o_ready forced to all-zero while rst_n=0.
  - Reset mid-transfer discards the held word; no partial state survives.
- Load enable: ld = !o_valid || in_ready. Output register may refill in the same cycle it drains, giving full throughput of 1 word/cycle.
- Candidate channel sel:
  - Fixed mode: sel = in_selector. If in_selector >= NCH, no candidate.
  - Round-robin mode: first c with in_valid[c]=1, searching (last+1) mod NCH, (last+2) mod NCH, … wrapping through NCH-1 to 0. If no channel is valid, no candidate.
- Handshake:
  - o_ready[sel] = ld && candidate exists. All other o_ready bits are 0.
  - Exactly one bit may be high, and only when that channel is valid (RR) or selected (fixed).
  - In fixed mode, o_ready[sel] may be high while in_valid[sel]=0; no transfer occurs.
- Accept, when in_valid[sel] && o_ready[sel]:
  - Next edge: o_result <= in_data[sel], o_grant <= sel, o_valid <= 1, last <= sel.
  - last updates in both modes.
- Drain without refill (in_ready && o_valid && no accept): o_valid <= 0. o_result and o_grant hold their last values.
- Stall (o_valid && !in_ready): o_result, o_grant and o_valid hold. All o_ready are 0. Producers must hold data.
- Latency: exactly 1 clk from input accept to o_valid.
- Mode or selector changes take effect combinationally on the next candidate evaluation. A held word is unaffected.
- Non-power-of-2 NCH: round-robin wrap uses mod NCH, never 2**SW.
- Fairness: with all NCH channels continuously valid and in_ready=1, grants cycle 0,1,…,NCH-1,0,…

Decomposition:
- Package mux_pkg holds:
  - typedef enum logic {MODE_FIXED=0, MODE_RR=1} mode_e.
  - Function next_idx(idx, n) for modular increment.
- One sub-module, rr_picker (combinational). Inputs: in_valid, last. Outputs: found, idx. Rotating priority search.
- The top module holds the output register, the pointer, and the handshake logic.

Test Plan:
1. Reset and idle: rst_n=0 for 2 cycles with all in_valid=1 → o_valid=0, o_result=0, o_grant=0, o_ready=0. Release reset with in_valid=0 → o_valid stays 0.
2. Fixed-mode sweep, DW=4, NCH=4: mode=0, in_ready=1, selector 0..3, in_data channel c = c+5 → o_result=5,6,7,8, o_grant=0..3, each 1 cycle after accept. Additionally, check all selector × data combinations against a golden model, num_errors=0.
3. Round-robin fairness: mode=1, all valid, in_ready=1 for 8 cycles → o_grant sequence 0,1,2,3,0,1,2,3, one grant per cycle.
4. Sparse round-robin with wrap: only channels 1 and 3 valid, last=3 after reset sequence → grants 1,3,1,3; channel 0 and 2 o_ready always 0.
5. Backpressure: o_valid=1 with o_result=0xA, in_ready=0 for 3 cycles while channel 2 presents 0xB → o_result stays 0xA, o_ready=0. Raise in_ready → same edge loads 0xB, o_valid stays 1.
6. Reset mid-stream, plus NCH=3 build: assert rst_n=0 while o_valid=1 → next edge o_valid=0. With NCH=3 in round-robin and all valid → grants 0,1,2,0; never index 3.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N-to-1 round-robin multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Modular increment; wraps at n, not at the next power of two.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority search: first valid channel after last_i, wrapping mod NCH.
module rr_picker
    import mux_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] valid_i,
    input  logic [SW-1:0]  last_i,
    output logic           found_o,
    output logic [SW-1:0]  idx_o
);

    always_comb begin
        int unsigned cand;
        logic [SW-1:0] cand_idx;
        found_o  = 1'b0;
        idx_o    = '0;
        cand     = 32'(last_i);
        cand_idx = last_i;
        for (int k = 0; k < NCH; k++) begin
            cand     = next_idx(cand, NCH);
            cand_idx = SW'(cand);
            if (!found_o && valid_i[cand_idx]) begin
                found_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// Registered N-to-1 mux with valid/ready handshake, fixed or round-robin selection.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int unsigned DW  = 4,
    parameter int unsigned NCH = 4,
    parameter int unsigned SW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    o_ready,
    input  logic              in_mode,
    input  logic [SW-1:0]     in_selector,
    output logic [DW-1:0]     o_result,
    output logic              o_valid,
    output logic [SW-1:0]     o_grant,
    input  logic              in_ready
);

    logic          valid_q,  valid_d;
    logic [DW-1:0] result_q, result_d;
    logic [SW-1:0] grant_q,  grant_d;
    logic [SW-1:0] last_q,   last_d;

    mode_e         mode;
    logic          ld;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic          found;
    logic [SW-1:0] sel;
    logic [DW-1:0] sel_data;
    logic          accept;

    assign mode = mode_e'(in_mode);
    // Register may refill in the same cycle it drains.
    assign ld   = !valid_q || in_ready;

    rr_picker #(
        .NCH (NCH),
        .SW  (SW)
    ) u_rr_picker (
        .valid_i (in_valid),
        .last_i  (last_q),
        .found_o (rr_found),
        .idx_o   (rr_idx)
    );

    always_comb begin
        if (mode == MODE_RR) begin
            found = rr_found;
            sel   = rr_idx;
        end else begin
            found = 32'(in_selector) < NCH;
            sel   = in_selector;
        end
    end

    always_comb begin
        o_ready  = '0;
        sel_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel == SW'(c)) begin
                o_ready[c] = rst_n && ld && found;
                sel_data   = in_data[c*DW +: DW];
            end
        end
    end

    assign accept = |(o_ready & in_valid);

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        grant_d  = grant_q;
        last_d   = last_q;
        if (accept) begin
            valid_d  = 1'b1;
            result_d = sel_data;
            grant_d  = sel;
            last_d   = sel;
        end else if (in_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            grant_q  <= '0;
            last_q   <= SW'(NCH - 1);
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_grant  = grant_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: vector table plus hand-written sweeps (NCH=4 and NCH=3).
module tb_mux_nto1_rr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // NCH=4 instance
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  o_ready;
    logic        in_mode;
    logic [1:0]  in_selector;
    logic [3:0]  o_result;
    logic        o_valid;
    logic [1:0]  o_grant;
    logic        in_ready;

    mux_nto1_rr #(
        .DW  (4),
        .NCH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .o_ready     (o_ready),
        .in_mode     (in_mode),
        .in_selector (in_selector),
        .o_result    (o_result),
        .o_valid     (o_valid),
        .o_grant     (o_grant),
        .in_ready    (in_ready)
    );

    // NCH=3 instance
    logic        rst3_n;
    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  o_ready3;
    logic        in_mode3;
    logic [1:0]  in_selector3;
    logic [3:0]  o_result3;
    logic        o_valid3;
    logic [1:0]  o_grant3;
    logic        in_ready3;

    mux_nto1_rr #(
        .DW  (4),
        .NCH (3)
    ) dut3 (
        .clk         (clk),
        .rst_n       (rst3_n),
        .in_data     (in_data3),
        .in_valid    (in_valid3),
        .o_ready     (o_ready3),
        .in_mode     (in_mode3),
        .in_selector (in_selector3),
        .o_result    (o_result3),
        .o_valid     (o_valid3),
        .o_grant     (o_grant3),
        .in_ready    (in_ready3)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        rst_n;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [15:0] data;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [3:0]  exp_result;
        logic [1:0]  exp_grant;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic m, input logic [1:0] s,
                               input logic [3:0] va, input logic [15:0] d, input logic rd,
                               input logic [3:0] er, input logic ev, input logic [3:0] eres,
                               input logic [1:0] eg);
        vec_t t;
        t = '{rst_n: r, mode: m, sel: s, valid: va, data: d, rdy: rd, exp_ready: er,
              exp_valid: ev, exp_result: eres, exp_grant: eg};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = '0; in_mode = 1'b0; in_selector = '0;
        in_ready = 1'b1;
        rst3_n = 1'b0; in_data3 = '0; in_valid3 = '0; in_mode3 = 1'b0; in_selector3 = '0;
        in_ready3 = 1'b1;

        //         rst mode sel valid  data     rdy  ready  v  res   g
        // reset with all valid, then idle release
        tbl.push_back(v(0, 1, 0, 4'hF, 16'h8765, 1, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(0, 1, 0, 4'hF, 16'h8765, 1, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(1, 1, 0, 4'h0, 16'h8765, 1, 4'h0, 0, 4'h0, 0));
        // fixed sweep, channel c carries c+5
        tbl.push_back(v(1, 0, 0, 4'hF, 16'h8765, 1, 4'h1, 1, 4'h5, 0));
        tbl.push_back(v(1, 0, 1, 4'hF, 16'h8765, 1, 4'h2, 1, 4'h6, 1));
        tbl.push_back(v(1, 0, 2, 4'hF, 16'h8765, 1, 4'h4, 1, 4'h7, 2));
        tbl.push_back(v(1, 0, 3, 4'hF, 16'h8765, 1, 4'h8, 1, 4'h8, 3));
        // fixed select of an invalid channel: ready high, no transfer, word drains
        tbl.push_back(v(1, 0, 1, 4'hD, 16'h8765, 1, 4'h2, 0, 4'h8, 3));
        // round-robin fairness after reset
        tbl.push_back(v(0, 1, 0, 4'hF, 16'h8765, 1, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(1, 1, 0, 4'hF, 16'h8765, 1, 4'h1, 1, 4'h5, 0));
        tbl.push_back(v(1, 1, 0, 4'hF, 16'h8765, 1, 4'h2, 1, 4'h6, 1));
        tbl.push_back(v(1, 1, 0, 4'hF, 16'h8765, 1, 4'h4, 1, 4'h7, 2));
        tbl.push_back(v(1, 1, 0, 4'hF, 16'h8765, 1, 4'h8, 1, 4'h8, 3));
        tbl.push_back(v(1, 1, 0, 4'hF, 16'h8765, 1, 4'h1, 1, 4'h5, 0));
        tbl.push_back(v(1, 1, 0, 4'hF, 16'h8765, 1, 4'h2, 1, 4'h6, 1));
        tbl.push_back(v(1, 1, 0, 4'hF, 16'h8765, 1, 4'h4, 1, 4'h7, 2));
        tbl.push_back(v(1, 1, 0, 4'hF, 16'h8765, 1, 4'h8, 1, 4'h8, 3));
        // sparse round-robin, channels 1 and 3 only
        tbl.push_back(v(0, 1, 0, 4'hA, 16'h8765, 1, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(1, 1, 0, 4'hA, 16'h8765, 1, 4'h2, 1, 4'h6, 1));
        tbl.push_back(v(1, 1, 0, 4'hA, 16'h8765, 1, 4'h8, 1, 4'h8, 3));
        tbl.push_back(v(1, 1, 0, 4'hA, 16'h8765, 1, 4'h2, 1, 4'h6, 1));
        tbl.push_back(v(1, 1, 0, 4'hA, 16'h8765, 1, 4'h8, 1, 4'h8, 3));
        // backpressure: hold 0xA while channel 2 offers 0xB, then drain+refill
        tbl.push_back(v(1, 0, 0, 4'h1, 16'h0B0A, 1, 4'h1, 1, 4'hA, 0));
        tbl.push_back(v(1, 0, 2, 4'h4, 16'h0B0A, 0, 4'h0, 1, 4'hA, 0));
        tbl.push_back(v(1, 0, 2, 4'h4, 16'h0B0A, 0, 4'h0, 1, 4'hA, 0));
        tbl.push_back(v(1, 0, 2, 4'h4, 16'h0B0A, 0, 4'h0, 1, 4'hA, 0));
        tbl.push_back(v(1, 0, 2, 4'h4, 16'h0B0A, 1, 4'h4, 1, 4'hB, 2));
        // reset while a word is held
        tbl.push_back(v(0, 0, 2, 4'h4, 16'h0B0A, 0, 4'h0, 0, 4'h0, 0));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; in_mode = tbl[i].mode; in_selector = tbl[i].sel;
            in_valid = tbl[i].valid; in_data = tbl[i].data; in_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d o_ready", i), 32'(o_ready), 32'(tbl[i].exp_ready));
            step();
            chk($sformatf("vec%0d o_valid", i), 32'(o_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d o_result", i), 32'(o_result), 32'(tbl[i].exp_result));
            chk($sformatf("vec%0d o_grant", i), 32'(o_grant), 32'(tbl[i].exp_grant));
        end

        // Fixed mode: every selector x data value on the chosen channel.
        rst_n = 1'b1; in_mode = 1'b0; in_valid = 4'hF; in_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 16; d++) begin
                logic [15:0] word;
                word = 16'h8765;
                word[s*4 +: 4] = 4'(d);
                in_data = word; in_selector = 2'(s);
                step();
                chk($sformatf("sweep s%0d d%0d result", s, d), 32'(o_result), 32'(d));
                chk($sformatf("sweep s%0d d%0d grant", s, d), 32'(o_grant), 32'(s));
            end
        end

        // NCH=3: round-robin wraps 0,1,2,0 and never reaches index 3.
        step();
        rst3_n = 1'b1; in_mode3 = 1'b1; in_valid3 = 3'b111; in_data3 = 12'h321;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("n3 rr%0d o_ready", k), 32'(o_ready3), 32'(1 << (k % 3)));
            step();
            chk($sformatf("n3 rr%0d grant", k), 32'(o_grant3), 32'(k % 3));
            chk($sformatf("n3 rr%0d result", k), 32'(o_result3), 32'((k % 3) + 1));
        end
        // Fixed selector beyond NCH: no candidate, held word drains.
        in_mode3 = 1'b0; in_selector3 = 2'd3;
        #1;
        chk("n3 sel3 o_ready", 32'(o_ready3), 32'd0);
        step();
        chk("n3 sel3 o_valid", 32'(o_valid3), 32'd0);
        chk("n3 sel3 grant hold", 32'(o_grant3), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
